// File: rtl/alu_issue_stage_if.sv
// Handshake and datapath bundle between the register-read stage, the ID/EX
// issue register and the ALU.
interface alu_issue_stage_if #(
    parameter int WIDTH   = 32,
    parameter int REGBITS = 5
);
    logic               flush;
    logic               inValid;
    logic               inReady;
    logic [31:0]        instr;
    logic [WIDTH-1:0]   rsData;
    logic [WIDTH-1:0]   rtData;
    logic               exmemWrite;
    logic [REGBITS-1:0] exmemRd;
    logic [WIDTH-1:0]   exmemResult;
    logic               memwbWrite;
    logic [REGBITS-1:0] memwbRd;
    logic [WIDTH-1:0]   memwbResult;
    logic               outValid;
    logic               outReady;
    logic [WIDTH-1:0]   content1;
    logic [WIDTH-1:0]   content2;
    logic [2:0]         ALUControlBit;
    logic [REGBITS-1:0] destReg;
    logic               regWrite;
    logic               memRead;
    logic               memWrite;
    logic [WIDTH-1:0]   storeData;
    logic               illegal;

    modport master (
        output flush, inValid, instr, rsData, rtData,
        output exmemWrite, exmemRd, exmemResult,
        output memwbWrite, memwbRd, memwbResult,
        output outReady,
        input  inReady, outValid, content1, content2, ALUControlBit,
        input  destReg, regWrite, memRead, memWrite, storeData, illegal
    );

    modport slave (
        input  flush, inValid, instr, rsData, rtData,
        input  exmemWrite, exmemRd, exmemResult,
        input  memwbWrite, memwbRd, memwbResult,
        input  outReady,
        output inReady, outValid, content1, content2, ALUControlBit,
        output destReg, regWrite, memRead, memWrite, storeData, illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX issue register: decodes a MIPS word into ALU control, picks and
// forwards operands, and holds them behind a valid/ready handshake.
//
// state | meaning
// EMPTY | no live instruction in the output register
// FULL  | output register holds an instruction awaiting consumption
module alu_issue_stage #(
    parameter int WIDTH   = 32,
    parameter int REGBITS = 5
) (
    input logic         clock,
    input logic         reset,
    alu_issue_stage_if.slave bus
);
    typedef enum logic {EMPTY, FULL} stateT;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_NOR = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    stateT stateQ, stateD;

    logic               capture;
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic [REGBITS-1:0] rsField;
    logic [REGBITS-1:0] rtField;
    logic [REGBITS-1:0] rdField;
    logic [4:0]         shamt;
    logic [15:0]        imm;
    logic [WIDTH-1:0]   immSext;
    logic [WIDTH-1:0]   immZext;
    logic [WIDTH-1:0]   shamtZext;
    logic [WIDTH-1:0]   rsFwd;
    logic [WIDTH-1:0]   rtFwd;

    logic [2:0]         aluD;
    logic [WIDTH-1:0]   opAD;
    logic [WIDTH-1:0]   opBD;
    logic [REGBITS-1:0] destD;
    logic               wrD;
    logic               mrD;
    logic               mwD;
    logic               illD;
    logic               regWriteD;

    assign opcode    = bus.instr[31:26];
    assign rsField   = bus.instr[25:21];
    assign rtField   = bus.instr[20:16];
    assign rdField   = bus.instr[15:11];
    assign shamt     = bus.instr[10:6];
    assign funct     = bus.instr[5:0];
    assign imm       = bus.instr[15:0];
    assign immSext   = {{(WIDTH-16){imm[15]}}, imm};
    assign immZext   = {{(WIDTH-16){1'b0}}, imm};
    assign shamtZext = {{(WIDTH-5){1'b0}}, shamt};

    assign bus.outValid = (stateQ == FULL);
    assign bus.inReady  = (stateQ == EMPTY) || bus.outReady;
    assign capture      = bus.inValid && bus.inReady && !bus.flush;

    always_ff @(posedge clock) begin
        if (reset) begin
            stateQ <= EMPTY;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        if (bus.flush) begin
            stateD = EMPTY;
        end else if (capture) begin
            stateD = FULL;
        end else if (stateQ == FULL && bus.outReady) begin
            stateD = EMPTY;
        end
    end

    // EX/MEM is younger than MEM/WB, so it wins; $0 is hard-wired and never forwarded.
    always_comb begin
        rsFwd = bus.rsData;
        if (bus.exmemWrite && bus.exmemRd == rsField && rsField != '0) begin
            rsFwd = bus.exmemResult;
        end else if (bus.memwbWrite && bus.memwbRd == rsField && rsField != '0) begin
            rsFwd = bus.memwbResult;
        end
    end

    always_comb begin
        rtFwd = bus.rtData;
        if (bus.exmemWrite && bus.exmemRd == rtField && rtField != '0) begin
            rtFwd = bus.exmemResult;
        end else if (bus.memwbWrite && bus.memwbRd == rtField && rtField != '0) begin
            rtFwd = bus.memwbResult;
        end
    end

    always_comb begin
        aluD  = ALU_ADD;
        opAD  = rsFwd;
        opBD  = rtFwd;
        destD = rtField;
        wrD   = 1'b0;
        mrD   = 1'b0;
        mwD   = 1'b0;
        illD  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                destD = rdField;
                wrD   = 1'b1;
                case (funct)
                    6'b100000, 6'b100001: aluD = ALU_ADD;
                    6'b100010, 6'b100011: aluD = ALU_SUB;
                    6'b100100:            aluD = ALU_AND;
                    6'b100101:            aluD = ALU_OR;
                    6'b100111:            aluD = ALU_NOR;
                    6'b101010, 6'b101011: aluD = ALU_SLT;
                    6'b000000: begin
                        aluD = ALU_SLL;
                        opAD = rtFwd;
                        opBD = shamtZext;
                    end
                    6'b000010: begin
                        aluD = ALU_SRL;
                        opAD = rtFwd;
                        opBD = shamtZext;
                    end
                    default: illD = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                aluD = ALU_ADD;
                opBD = immSext;
                wrD  = 1'b1;
            end
            OP_SLTI: begin
                aluD = ALU_SLT;
                opBD = immSext;
                wrD  = 1'b1;
            end
            OP_ANDI: begin
                aluD = ALU_AND;
                opBD = immZext;
                wrD  = 1'b1;
            end
            OP_ORI: begin
                aluD = ALU_OR;
                opBD = immZext;
                wrD  = 1'b1;
            end
            OP_LW: begin
                aluD = ALU_ADD;
                opBD = immSext;
                wrD  = 1'b1;
                mrD  = 1'b1;
            end
            OP_SW: begin
                aluD = ALU_ADD;
                opBD = immSext;
                mwD  = 1'b1;
            end
            OP_BEQ: begin
                aluD = ALU_SUB;
            end
            default: illD = 1'b1;
        endcase
        // Illegal words still travel down as valid so the trap logic sees them.
        if (illD) begin
            aluD = ALU_ADD;
            wrD  = 1'b0;
            mrD  = 1'b0;
            mwD  = 1'b0;
        end
    end

    assign regWriteD = wrD && (destD != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.content1      <= '0;
            bus.content2      <= '0;
            bus.ALUControlBit <= '0;
            bus.destReg       <= '0;
            bus.regWrite      <= 1'b0;
            bus.memRead       <= 1'b0;
            bus.memWrite      <= 1'b0;
            bus.storeData     <= '0;
            bus.illegal       <= 1'b0;
        end else if (bus.flush) begin
            bus.regWrite <= 1'b0;
            bus.memRead  <= 1'b0;
            bus.memWrite <= 1'b0;
        end else if (capture) begin
            bus.content1      <= opAD;
            bus.content2      <= opBD;
            bus.ALUControlBit <= aluD;
            bus.destReg       <= destD;
            bus.regWrite      <= regWriteD;
            bus.memRead       <= mrD;
            bus.memWrite      <= mwD;
            bus.storeData     <= rtFwd;
            bus.illegal       <= illD;
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: decode/forward vector table through
// a scoreboard queue, then stall, flush and reset sequences.
module tb_alu_issue_stage;
    typedef struct {
        logic [31:0] instr;
        logic [31:0] rsD;
        logic [31:0] rtD;
        logic        exW;
        logic [4:0]  exRd;
        logic [31:0] exRes;
        logic        wbW;
        logic [4:0]  wbRd;
        logic [31:0] wbRes;
        logic [31:0] c1;
        logic [31:0] c2;
        logic [2:0]  alu;
        logic [4:0]  dest;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        ill;
        logic        dc;
        logic [31:0] sd;
    } vecT;

    logic clock;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    vecT  vecs[20];
    vecT  sbq[$];
    vecT  cur;

    alu_issue_stage_if #(.WIDTH(32), .REGBITS(5)) bus ();

    alu_issue_stage #(.WIDTH(32), .REGBITS(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic vecT mk(
        input logic [31:0] instr, input logic [31:0] rsD, input logic [31:0] rtD,
        input logic exW, input logic [4:0] exRd, input logic [31:0] exRes,
        input logic wbW, input logic [4:0] wbRd, input logic [31:0] wbRes,
        input logic [31:0] c1, input logic [31:0] c2, input logic [2:0] alu,
        input logic [4:0] dest, input logic rw, input logic mr, input logic mw,
        input logic ill, input logic dc, input logic [31:0] sd);
        vecT v;
        v.instr = instr; v.rsD = rsD; v.rtD = rtD;
        v.exW = exW; v.exRd = exRd; v.exRes = exRes;
        v.wbW = wbW; v.wbRd = wbRd; v.wbRes = wbRes;
        v.c1 = c1; v.c2 = c2; v.alu = alu; v.dest = dest;
        v.rw = rw; v.mr = mr; v.mw = mw; v.ill = ill; v.dc = dc; v.sd = sd;
        return v;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input vecT v);
        bus.instr       = v.instr;
        bus.rsData      = v.rsD;
        bus.rtData      = v.rtD;
        bus.exmemWrite  = v.exW;
        bus.exmemRd     = v.exRd;
        bus.exmemResult = v.exRes;
        bus.memwbWrite  = v.wbW;
        bus.memwbRd     = v.wbRd;
        bus.memwbResult = v.wbRes;
    endtask

    task automatic cmpOut(input string tag, input vecT e);
        chk({tag, ".outValid"}, {31'd0, bus.outValid}, 32'd1);
        chk({tag, ".alu"}, {29'd0, bus.ALUControlBit}, {29'd0, e.alu});
        chk({tag, ".regWrite"}, {31'd0, bus.regWrite}, {31'd0, e.rw});
        chk({tag, ".memRead"}, {31'd0, bus.memRead}, {31'd0, e.mr});
        chk({tag, ".memWrite"}, {31'd0, bus.memWrite}, {31'd0, e.mw});
        chk({tag, ".illegal"}, {31'd0, bus.illegal}, {31'd0, e.ill});
        chk({tag, ".storeData"}, bus.storeData, e.sd);
        if (!e.dc) begin
            chk({tag, ".content1"}, bus.content1, e.c1);
            chk({tag, ".content2"}, bus.content2, e.c2);
            chk({tag, ".destReg"}, {27'd0, bus.destReg}, {27'd0, e.dest});
        end
    endtask

    task automatic popCheck(input string tag);
        vecT e;
        if (sbq.size() == 0) begin
            chk({tag, ".sbEmpty"}, 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            cmpOut(tag, e);
        end
    endtask

    task automatic chkZero(input string tag);
        chk({tag, ".outValid"}, {31'd0, bus.outValid}, 32'd0);
        chk({tag, ".content1"}, bus.content1, 32'd0);
        chk({tag, ".content2"}, bus.content2, 32'd0);
        chk({tag, ".alu"}, {29'd0, bus.ALUControlBit}, 32'd0);
        chk({tag, ".destReg"}, {27'd0, bus.destReg}, 32'd0);
        chk({tag, ".regWrite"}, {31'd0, bus.regWrite}, 32'd0);
        chk({tag, ".memRead"}, {31'd0, bus.memRead}, 32'd0);
        chk({tag, ".memWrite"}, {31'd0, bus.memWrite}, 32'd0);
        chk({tag, ".storeData"}, bus.storeData, 32'd0);
        chk({tag, ".illegal"}, {31'd0, bus.illegal}, 32'd0);
    endtask

    initial begin
        //            instr         rsD          rtD          exW exRd exRes    wbW wbRd wbRes   c1           c2           alu   dest rw mr mw il dc sd
        vecs[0]  = mk(32'h00221820, 32'd5,       32'd7,       0, 0,  0,       0, 0,  0,      32'd5,       32'd7,       3'd2, 3,  1, 0, 0, 0, 0, 32'd7);
        vecs[1]  = mk(32'h2024FFFF, 32'hAAAA,    32'hBBBB,    1, 1,  32'h10,  1, 1,  32'h20, 32'h10,      32'hFFFFFFFF,3'd2, 4,  1, 0, 0, 0, 0, 32'hBBBB);
        vecs[2]  = mk(32'h00051100, 32'h99,      32'd3,       0, 0,  0,       0, 0,  0,      32'd3,       32'd4,       3'd4, 2,  1, 0, 0, 0, 0, 32'd3);
        vecs[3]  = mk(32'h34068000, 32'd0,       32'h77,      0, 0,  0,       0, 0,  0,      32'd0,       32'h8000,    3'd1, 6,  1, 0, 0, 0, 0, 32'h77);
        vecs[4]  = mk(32'h01093822, 32'd1,       32'd2,       1, 8,  32'h100, 1, 9,  32'h200,32'h100,     32'h200,     3'd6, 7,  1, 0, 0, 0, 0, 32'h200);
        vecs[5]  = mk(32'h000B5024, 32'h12,      32'd3,       1, 0,  32'hDEAD,1, 11, 32'h5,  32'h12,      32'h5,       3'd0, 10, 1, 0, 0, 0, 0, 32'h5);
        vecs[6]  = mk(32'h01AE6027, 32'h44,      32'h55,      0, 13, 32'hBAD, 1, 13, 32'h33, 32'h33,      32'h55,      3'd3, 12, 1, 0, 0, 0, 0, 32'h55);
        vecs[7]  = mk(32'h0043082A, 32'd1,       32'd2,       0, 0,  0,       0, 0,  0,      32'd1,       32'd2,       3'd7, 1,  1, 0, 0, 0, 0, 32'd2);
        vecs[8]  = mk(32'h00C72825, 32'hF0,      32'h0F,      0, 0,  0,       0, 0,  0,      32'hF0,      32'h0F,      3'd1, 5,  1, 0, 0, 0, 0, 32'h0F);
        vecs[9]  = mk(32'h000A4FC2, 32'd1,       32'h80000000,0, 0,  0,       0, 0,  0,      32'h80000000,32'd31,      3'd5, 9,  1, 0, 0, 0, 0, 32'h80000000);
        vecs[10] = mk(32'h8FA8FFFC, 32'h1000,    32'd9,       0, 0,  0,       0, 0,  0,      32'h1000,    32'hFFFFFFFC,3'd2, 8,  1, 1, 0, 0, 0, 32'd9);
        vecs[11] = mk(32'hAFA90008, 32'h2000,    32'h1234,    1, 9,  32'hCAFE,0, 0,  0,      32'h2000,    32'd8,       3'd2, 9,  0, 0, 1, 0, 0, 32'hCAFE);
        vecs[12] = mk(32'h10220010, 32'd3,       32'd3,       0, 0,  0,       0, 0,  0,      32'd3,       32'd3,       3'd6, 2,  0, 0, 0, 0, 0, 32'd3);
        vecs[13] = mk(32'h3083FFFF, 32'hABCD1234,32'd0,       0, 0,  0,       0, 0,  0,      32'hABCD1234,32'h0000FFFF,3'd0, 3,  1, 0, 0, 0, 0, 32'd0);
        vecs[14] = mk(32'h28C5FFFE, 32'd7,       32'd0,       0, 0,  0,       0, 0,  0,      32'd7,       32'hFFFFFFFE,3'd7, 5,  1, 0, 0, 0, 0, 32'd0);
        vecs[15] = mk(32'hFC000000, 32'd1,       32'd2,       0, 0,  0,       0, 0,  0,      32'd0,       32'd0,       3'd2, 0,  0, 0, 0, 1, 1, 32'd2);
        vecs[16] = mk(32'h00220020, 32'd5,       32'd7,       0, 0,  0,       0, 0,  0,      32'd5,       32'd7,       3'd2, 0,  0, 0, 0, 0, 0, 32'd7);
        vecs[17] = mk(32'h00000000, 32'h11,      32'h66,      0, 0,  0,       0, 0,  0,      32'h66,      32'd0,       3'd4, 0,  0, 0, 0, 0, 0, 32'h66);
        vecs[18] = mk(32'h0022183F, 32'd5,       32'd7,       0, 0,  0,       0, 0,  0,      32'd0,       32'd0,       3'd2, 0,  0, 0, 0, 1, 1, 32'd7);
        vecs[19] = mk(32'h24627FFF, 32'h10,      32'd0,       0, 0,  0,       0, 0,  0,      32'h10,      32'h7FFF,    3'd2, 2,  1, 0, 0, 0, 0, 32'd0);

        reset        = 1'b1;
        bus.flush    = 1'b0;
        bus.inValid  = 1'b0;
        bus.outReady = 1'b1;
        drive(vecs[0]);
        repeat (2) tick();
        reset = 1'b0;
        #1;
        chkZero("reset");
        chk("reset.inReady", {31'd0, bus.inReady}, 32'd1);

        // Back-to-back stream through the scoreboard.
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i]);
            bus.inValid = 1'b1;
            #1;
            chk($sformatf("v%0d.inReady", i), {31'd0, bus.inReady}, 32'd1);
            sbq.push_back(vecs[i]);
            tick();
            popCheck($sformatf("v%0d", i));
        end
        bus.inValid = 1'b0;
        tick();
        chk("drain.outValid", {31'd0, bus.outValid}, 32'd0);

        // Stall: hold addi (forwarded rs) while the next instruction waits.
        drive(vecs[1]);
        bus.inValid = 1'b1;
        sbq.push_back(vecs[1]);
        tick();
        popCheck("stallA");
        bus.outReady = 1'b0;
        drive(vecs[10]);
        bus.exmemWrite  = 1'b1;
        bus.exmemRd     = 5'd1;
        bus.exmemResult = 32'h999;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall%0d.inReady", i), {31'd0, bus.inReady}, 32'd0);
            tick();
            cur = vecs[1];
            cmpOut($sformatf("stall%0d", i), cur);
        end
        drive(vecs[10]);
        bus.outReady = 1'b1;
        #1;
        chk("release.inReady", {31'd0, bus.inReady}, 32'd1);
        sbq.push_back(vecs[10]);
        tick();
        popCheck("stallB");

        // Flush kills the held lw and refuses the incoming add.
        drive(vecs[0]);
        bus.inValid = 1'b1;
        bus.flush   = 1'b1;
        tick();
        chk("flush.outValid", {31'd0, bus.outValid}, 32'd0);
        chk("flush.regWrite", {31'd0, bus.regWrite}, 32'd0);
        chk("flush.memRead", {31'd0, bus.memRead}, 32'd0);
        chk("flush.memWrite", {31'd0, bus.memWrite}, 32'd0);
        bus.flush   = 1'b0;
        bus.inValid = 1'b0;
        tick();
        chk("postflush.outValid", {31'd0, bus.outValid}, 32'd0);

        // Reset mid-transfer drops the held instruction and beats a pending capture.
        drive(vecs[11]);
        bus.inValid = 1'b1;
        sbq.push_back(vecs[11]);
        tick();
        popCheck("preReset");
        bus.outReady = 1'b0;
        reset        = 1'b1;
        tick();
        chkZero("midReset");
        reset        = 1'b0;
        bus.inValid  = 1'b0;
        bus.outReady = 1'b1;
        tick();
        chk("afterReset.outValid", {31'd0, bus.outValid}, 32'd0);
        chk("afterReset.sbLeft", sbq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline stage directly upstream of the ALU.
- Accepts a fetched instruction word plus register-file read data through a valid/ready handshake.
- Decodes the opcode and funct fields into the 3-bit ALU control code, selects and extends the second operand, and applies EX/MEM and MEM/WB forwarding.
- Registers content1, content2 and ALUControlBit, together with the write-back control bits consumed by the downstream stages.

Parameters:
- WIDTH, 32, datapath width. Only 32 is supported.
- REGBITS, 5, register-specifier width.

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous kill of the held and incoming instruction
- inValid  in  1  instr, rsData and rtData are valid
- inReady  out  1  stage can accept this cycle
- instr  in  32  MIPS instruction word
- rsData  in  WIDTH  register-file value of rs
- rtData  in  WIDTH  register-file value of rt
- exmemWrite  in  1  EX/MEM instruction writes a register
- exmemRd  in  REGBITS  EX/MEM destination register
- exmemResult  in  WIDTH  EX/MEM ALU result
- memwbWrite  in  1  MEM/WB instruction writes a register
- memwbRd  in  REGBITS  MEM/WB destination register
- memwbResult  in  WIDTH  MEM/WB write-back value
- outValid  out  1  registered outputs hold a live instruction
- outReady  in  1  downstream consumes this cycle
- content1  out  WIDTH  ALU operand A
- content2  out  WIDTH  ALU operand B
- ALUControlBit  out  3  000 And, 001 Or, 010 Add, 011 Nor, 100 Sll, 101 Srl, 110 Sub, 111 Slt
- destReg  out  REGBITS  write-back register
- regWrite  out  1  instruction writes destReg
- memRead  out  1  lw
- memWrite  out  1  sw
- storeData  out  WIDTH  forwarded rt value, used by sw
- illegal  out  1  unsupported opcode/funct

Behaviour:
- Reset: on the clock edge with reset=1, every output register clears to 0 (outValid, content1, content2, ALUControlBit, destReg, regWrite, memRead, memWrite, storeData, illegal).
- Reset has priority over flush and over the handshake. Reset mid-transfer drops the instruction.
- Handshake:
  - inReady = !outValid || outReady (combinational).
  - Capture occurs when inValid && inReady && !flush.
  - After a capture, the outputs update on the next edge: 1-cycle latency.
  - If outValid && outReady with no capture, outValid clears on the next edge.
  - While outValid && !outReady, all outputs hold stable.
  - Simultaneous consume and capture gives back-to-back throughput of 1 instruction per cycle.
- Flush: on the next edge outValid=0 and regWrite, memRead and memWrite clear to 0. A concurrent input is not captured. Data outputs may hold their previous values.
- Forwarding is evaluated at capture only and applied separately to the rs and rt fields:
  - Priority: EX/MEM match (exmemWrite && exmemRd==field && field!=0), then MEM/WB match, then register-file data.
  - Register 0 is never forwarded.
  - Operands held during a stall are not re-forwarded. The hazard unit must hold inValid low for load-use hazards.
- Decode, R-type (opcode 000000), by funct:
  - 100000/100001 -> Add
  - 100010/100011 -> Sub
  - 100100 And, 100101 Or, 100111 Nor
  - 101010/101011 -> Slt
  - For all of these: content1=rs, content2=rt, destReg=rd.
  - 000000 sll and 000010 srl: content1=rt, content2 = zero-extended shamt (instr[10:6]), destReg=rd.
- Decode, I-type:
  - addi 001000 / addiu 001001: Add, sign-extended immediate.
  - slti 001010: Slt, sign-extended immediate.
  - andi 001100: And, zero-extended immediate.
  - ori 001101: Or, zero-extended immediate.
  - lw 100011: Add, sign-extended immediate, memRead=1.
  - sw 101011: Add, sign-extended immediate, memWrite=1, regWrite=0.
  - beq 000100: Sub, content2=rt, regWrite=0.
  - I-type destReg = rt. Immediate = instr[15:0].
- regWrite: 1 for every ALU R/I-type op and lw, but forced to 0 when destReg==0.
- storeData is always the forwarded rt value.
- Illegal or unsupported encoding: illegal=1, ALUControlBit=Add, regWrite, memRead and memWrite all 0, outValid still 1 so the trap logic downstream sees it.
- The nop (all-zero word) decodes as sll $0: legal, regWrite=0.

Test Plan:
- Reset held 2 cycles, then released -> all outputs 0, inReady=1.
- add $3,$1,$2 (0x00221820), rsData=5, rtData=7, no forwarding -> next cycle outValid=1, content1=5, content2=7, ALUControlBit=010, destReg=3, regWrite=1.
- addi $4,$1,-1 (0x2024FFFF) with exmemWrite=1, exmemRd=1, exmemResult=0x10 and memwbRd=1, memwbResult=0x20 -> content1=0x10 (EX/MEM wins), content2=0xFFFFFFFF, ALUControlBit=010, destReg=4.
- sll $2,$5,4 (0x00051100), rtData=3 -> content1=3, content2=4, ALUControlBit=100; ori $6,$0,0x8000 -> content2=0x00008000, ALUControlBit=001.
- Stall and flush:
  - Hold outReady=0 for 3 cycles with inValid=1 -> outputs stable, inReady=0 throughout; on outReady=1, the next instruction is captured back-to-back.
  - Assert flush with inValid=1 -> outValid=0 next cycle, input not captured.
- Opcode 0x3F word and a write to $0 (add $0,$1,$2) -> first gives illegal=1, regWrite=0; second gives illegal=0, regWrite=0, destReg=0.
